// File: rtl/sha3_pkg.sv
// Shared SHA-3 types and constants for the absorb-side blocks.
package sha3_pkg;

    typedef logic [63:0] lane_t;

    localparam int RATE_SHA3_224 = 18;
    localparam int RATE_SHA3_256 = 17;
    localparam int RATE_SHA3_384 = 13;
    localparam int RATE_SHA3_512 = 9;

    localparam logic [7:0] DOMAIN_SHA3  = 8'h06;
    localparam logic [7:0] DOMAIN_SHAKE = 8'h1F;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        FULL  = 2'd1,
        EXTRA = 2'd2
    } padder_state_t;

endpackage

// File: rtl/sha3_pad_lane.sv
// Combinational padding of one 64-bit lane: keeps bytes 0..n-1 of the word,
// optionally places the domain byte at byte n, zeroes the rest, and sets
// bit 63 when this is the top lane of a final block.
module sha3_pad_lane
    import sha3_pkg::*;
(
    input  lane_t       word_i,
    input  logic [3:0]  n_i,
    input  logic        pad_en_i,
    input  logic        top_i,
    input  logic [7:0]  domain_i,
    output lane_t       lane_o
);

    // Byte-wise select: message byte, domain byte, or zero; then final pad bit.
    always_comb begin
        lane_o = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n_i) begin
                lane_o[8*k +: 8] = word_i[8*k +: 8];
            end else if ((4'(k) == n_i) && pad_en_i) begin
                lane_o[8*k +: 8] = domain_i;
            end
        end
        if (top_i) begin
            lane_o[63] = 1'b1;
        end
    end

endmodule

// File: rtl/sha3_absorb_padder.sv
// Collects a little-endian 64-bit word stream into rate-sized blocks,
// applies SHA-3/SHAKE multi-rate padding and offers each block to the
// absorb controller over a valid/ready handshake.
module sha3_absorb_padder
    import sha3_pkg::*;
#(
    parameter int         RATE_LANES  = 17,
    parameter logic [7:0] DOMAIN_BYTE = 8'h06
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              in_data,
    input  logic [3:0]               in_bytes,
    input  logic                     in_last,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [RATE_LANES*64-1:0] blk_data,
    output logic                     blk_first,
    output logic                     blk_last,
    output logic                     blk_valid,
    input  logic                     blk_ready
);

    // Wide enough for any legal rate (up to 21 lanes) plus one.
    localparam int CNT_W = 5;

    padder_state_t                 state_q, state_d;
    logic [CNT_W-1:0]              lane_cnt_q, lane_cnt_d;
    logic                          first_pending_q, first_pending_d;
    logic                          last_q, last_d;
    logic                          extra_pending_q, extra_pending_d;
    logic [RATE_LANES-1:0][63:0]   buf_q, buf_d;

    logic       in_fire;
    logic       blk_fire;
    logic [3:0] n_clamp;
    logic       full_word;
    logic       cnt_top;
    logic       extra_case;

    assign in_fire    = in_valid && in_ready;
    assign blk_fire   = blk_valid && blk_ready;
    assign n_clamp    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    assign full_word  = (n_clamp == 4'd8);
    assign cnt_top    = (lane_cnt_q == CNT_W'(RATE_LANES - 1));
    // A full final word landing in the top lane leaves no room for padding,
    // so the padding goes into a separate all-pad block.
    assign extra_case = full_word && cnt_top;

    assign blk_data = buf_q;

    // Per-lane next value: word capture, padded final lane, clear, or pad-only block.
    for (genvar gi = 0; gi < RATE_LANES; gi++) begin : g_lane
        localparam bit IS_TOP = (gi == RATE_LANES - 1);

        logic       is_cur;
        logic       is_next;
        logic       at_or_above;
        lane_t      pad_word;
        logic [3:0] pad_n;
        logic       pad_en;
        logic       pad_top;
        lane_t      padded;
        lane_t      lane_d;

        assign is_cur      = (lane_cnt_q == CNT_W'(gi));
        assign is_next     = ((lane_cnt_q + CNT_W'(1)) == CNT_W'(gi));
        assign at_or_above = (lane_cnt_q <= CNT_W'(gi));
        assign pad_word    = is_cur ? in_data : '0;
        assign pad_n       = is_cur ? n_clamp : 4'd0;
        // Domain byte sits right after the last message byte, which is the
        // next lane's byte 0 when the final word is full.
        assign pad_en      = (is_cur && !full_word) || (is_next && full_word);
        assign pad_top     = IS_TOP && !extra_case;

        sha3_pad_lane u_pad (
            .word_i   (pad_word),
            .n_i      (pad_n),
            .pad_en_i (pad_en),
            .top_i    (pad_top),
            .domain_i (DOMAIN_BYTE),
            .lane_o   (padded)
        );

        // Select the lane's next contents according to the current state.
        always_comb begin
            lane_d = buf_q[gi];
            case (state_q)
                FILL: begin
                    if (in_fire) begin
                        if (!in_last) begin
                            if (is_cur) begin
                                lane_d = in_data;
                            end
                        end else if (at_or_above) begin
                            lane_d = padded;
                        end
                    end
                end
                FULL: begin
                    if (blk_fire && !extra_pending_q) begin
                        lane_d = '0;
                    end
                end
                EXTRA: begin
                    lane_d = '0;
                    if (gi == 0) begin
                        lane_d[7:0] = DOMAIN_BYTE;
                    end
                    if (IS_TOP) begin
                        lane_d[63] = 1'b1;
                    end
                end
                default: lane_d = buf_q[gi];
            endcase
        end

        assign buf_d[gi] = lane_d;
    end

    // Control next-state and handshake outputs.
    always_comb begin
        state_d         = state_q;
        lane_cnt_d      = lane_cnt_q;
        first_pending_d = first_pending_q;
        last_d          = last_q;
        extra_pending_d = extra_pending_q;
        in_ready        = 1'b0;
        blk_valid       = 1'b0;
        blk_first       = 1'b0;
        blk_last        = 1'b0;

        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_fire) begin
                    if (!in_last) begin
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                        if (cnt_top) begin
                            state_d = FULL;
                            last_d  = 1'b0;
                        end
                    end else if (extra_case) begin
                        state_d         = FULL;
                        last_d          = 1'b0;
                        extra_pending_d = 1'b1;
                    end else begin
                        state_d = FULL;
                        last_d  = 1'b1;
                    end
                end
            end
            FULL: begin
                blk_valid = 1'b1;
                blk_first = first_pending_q;
                blk_last  = last_q;
                if (blk_fire) begin
                    // Next block is a message start only after a final block.
                    first_pending_d = last_q;
                    if (extra_pending_q) begin
                        state_d = EXTRA;
                    end else begin
                        lane_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
            end
            EXTRA: begin
                state_d         = FULL;
                last_d          = 1'b1;
                extra_pending_d = 1'b0;
            end
            default: begin
                state_d    = FILL;
                lane_cnt_d = '0;
            end
        endcase
    end

    // State, counters and block buffer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= FILL;
            lane_cnt_q      <= '0;
            first_pending_q <= 1'b1;
            last_q          <= 1'b0;
            extra_pending_q <= 1'b0;
            buf_q           <= '0;
        end else begin
            state_q         <= state_d;
            lane_cnt_q      <= lane_cnt_d;
            first_pending_q <= first_pending_d;
            last_q          <= last_d;
            extra_pending_q <= extra_pending_d;
            buf_q           <= buf_d;
        end
    end

endmodule
